// File: rtl/mm_pkg.sv
// rtl/mm_pkg.sv - shared defaults, entry layout and history FSM states for the guess history buffer
package mm_pkg;

    localparam int PEGS_DEF    = 4;
    localparam int COLOR_W_DEF = 3;
    localparam int TURNS_DEF   = 8;
    localparam int CNT_W_DEF   = $clog2(PEGS_DEF + 1);

    // Reference layout at default sizes; parametrised instances use the same field order, flattened.
    typedef struct packed {
        logic [PEGS_DEF*COLOR_W_DEF-1:0] guess;
        logic [CNT_W_DEF-1:0]            exact;
        logic [CNT_W_DEF-1:0]            partial;
    } hist_entry_t;

    typedef enum logic [1:0] {
        EMPTY,
        LIVE,
        BROWSE,
        DONE
    } hist_state_t;

    function automatic int entry_width(input int pegs, input int color_w);
        return pegs * color_w + 2 * $clog2(pegs + 1);
    endfunction

endpackage

// File: rtl/hist_store.sv
// rtl/hist_store.sv - flop array of history entries, one write port, one asynchronous read port
module hist_store #(
    parameter int ENTRY_W = 18,
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [ENTRY_W-1:0] rd_data
);

    localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

    logic [ENTRY_W-1:0] mem [DEPTH];

    // Non-power-of-two depths leave unused address codes; they read as zero and never write.
    assign rd_data = ({1'b0, rd_addr} < DEPTH_C) ? mem[rd_addr] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && ({1'b0, wr_addr} < DEPTH_C)) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/guess_history_buf.sv
// rtl/guess_history_buf.sv - guess/feedback history with live view and operator browsing
module guess_history_buf
    import mm_pkg::*;
#(
    parameter int PEGS    = PEGS_DEF,
    parameter int COLOR_W = COLOR_W_DEF,
    parameter int TURNS   = TURNS_DEF,
    localparam int CNT_W  = $clog2(PEGS + 1),
    localparam int TURN_W = $clog2(TURNS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mode,
    input  logic                    btn_up,
    input  logic                    btn_down,
    input  logic                    btn_select,
    input  logic [PEGS*COLOR_W-1:0] guess,
    input  logic [CNT_W-1:0]        fb_exact,
    input  logic [CNT_W-1:0]        fb_partial,
    output logic [PEGS*COLOR_W-1:0] sel_guess,
    output logic [CNT_W-1:0]        sel_exact,
    output logic [CNT_W-1:0]        sel_partial,
    output logic [TURN_W-1:0]       sel_turn,
    output logic                    sel_valid,
    output logic [TURN_W:0]         turn_count,
    output logic                    last_turn,
    output logic                    full
);

    localparam int ENTRY_W = entry_width(PEGS, COLOR_W);
    localparam logic [TURN_W:0] TURNS_C = (TURN_W + 1)'(TURNS);
    localparam logic [TURN_W:0] LAST_C  = (TURN_W + 1)'(TURNS - 1);

    hist_state_t        state;
    logic               commit;
    logic [TURN_W-1:0]  latest;
    logic [TURN_W-1:0]  view_idx;
    logic [ENTRY_W-1:0] wr_data;
    logic [ENTRY_W-1:0] rd_data;

    assign last_turn = (turn_count == LAST_C);
    assign full      = (turn_count == TURNS_C);
    assign latest    = TURN_W'(turn_count - 1'b1);
    assign wr_data   = {guess, fb_exact, fb_partial};

    // DONE and BROWSE both refuse commits; LIVE is never full.
    assign commit = btn_select && !mode && ((state == EMPTY) || (state == LIVE));

    // Entry to present next cycle; also drives the store's read address.
    always_comb begin
        view_idx = sel_turn;
        case (state)
            LIVE, DONE: begin
                if (mode) view_idx = latest;
            end
            BROWSE: begin
                if (!mode)
                    view_idx = latest;
                else if (btn_up && !btn_down && (sel_turn != latest))
                    view_idx = sel_turn + 1'b1;
                else if (btn_down && !btn_up && (sel_turn != '0))
                    view_idx = sel_turn - 1'b1;
            end
            default: view_idx = sel_turn;
        endcase
    end

    hist_store #(
        .ENTRY_W (ENTRY_W),
        .DEPTH   (TURNS),
        .ADDR_W  (TURN_W)
    ) u_store (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (commit),
        .wr_addr (turn_count[TURN_W-1:0]),
        .wr_data (wr_data),
        .rd_addr (view_idx),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= EMPTY;
            turn_count  <= '0;
            sel_turn    <= '0;
            sel_guess   <= '0;
            sel_exact   <= '0;
            sel_partial <= '0;
            sel_valid   <= 1'b0;
        end else if (commit) begin
            // The store is written on this same edge, so present the inputs directly.
            turn_count  <= turn_count + 1'b1;
            sel_turn    <= turn_count[TURN_W-1:0];
            sel_guess   <= guess;
            sel_exact   <= fb_exact;
            sel_partial <= fb_partial;
            sel_valid   <= 1'b1;
            state       <= (turn_count == LAST_C) ? DONE : LIVE;
        end else if (state != EMPTY) begin
            sel_turn <= view_idx;
            {sel_guess, sel_exact, sel_partial} <= rd_data;
            case (state)
                LIVE, DONE: begin
                    if (mode) state <= BROWSE;
                end
                BROWSE: begin
                    if (!mode) state <= full ? DONE : LIVE;
                end
                default: state <= state;
            endcase
        end
    end

endmodule

// File: tb/tb_guess_history_buf.sv
// tb/tb_guess_history_buf.sv - randomized bench for guess_history_buf at 4x3x8 and 6x3x10
module tb_guess_history_buf;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mode = 1'b0;
    logic        btn_up = 1'b0;
    logic        btn_down = 1'b0;
    logic        btn_select = 1'b0;
    logic [17:0] guess_in = '0;
    logic [2:0]  fe = '0;
    logic [2:0]  fp = '0;

    logic [11:0] a_sg;
    logic [2:0]  a_se, a_sp, a_st;
    logic        a_sv, a_lt, a_fu;
    logic [3:0]  a_tc;
    logic [17:0] b_sg;
    logic [2:0]  b_se, b_sp;
    logic [3:0]  b_st;
    logic        b_sv, b_lt, b_fu;
    logic [4:0]  b_tc;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    guess_history_buf u_a (
        .clk(clk), .reset(reset), .mode(mode), .btn_up(btn_up), .btn_down(btn_down),
        .btn_select(btn_select), .guess(guess_in[11:0]), .fb_exact(fe), .fb_partial(fp),
        .sel_guess(a_sg), .sel_exact(a_se), .sel_partial(a_sp), .sel_turn(a_st),
        .sel_valid(a_sv), .turn_count(a_tc), .last_turn(a_lt), .full(a_fu)
    );

    guess_history_buf #(.PEGS(6), .COLOR_W(3), .TURNS(10)) u_b (
        .clk(clk), .reset(reset), .mode(mode), .btn_up(btn_up), .btn_down(btn_down),
        .btn_select(btn_select), .guess(guess_in), .fb_exact(fe), .fb_partial(fp),
        .sel_guess(b_sg), .sel_exact(b_se), .sel_partial(b_sp), .sel_turn(b_st),
        .sel_valid(b_sv), .turn_count(b_tc), .last_turn(b_lt), .full(b_fu)
    );

    // Observed outputs of both instances in a common 36-bit layout.
    logic [35:0] obs [2];
    always_comb begin
        obs[0] = {6'd0, a_sg, a_se, a_sp, 1'b0, a_st, a_sv, 1'b0, a_tc, a_lt, a_fu};
        obs[1] = {b_sg, b_se, b_sp, b_st, b_sv, b_tc, b_lt, b_fu};
    end

    // Reference model: a list of committed entries per instance plus a viewing cursor.
    int          turns [2] = '{8, 10};
    logic [17:0] gmask [2] = '{18'h00fff, 18'h3ffff};
    int          m_cnt [2];
    int          m_cur [2];
    bit          m_br  [2];
    logic [17:0] m_g   [2][10];
    logic [2:0]  m_e   [2][10];
    logic [2:0]  m_p   [2][10];

    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_cnt[i] = 0; m_cur[i] = 0; m_br[i] = 0;
                for (int k = 0; k < 10; k++) begin
                    m_g[i][k] = '0; m_e[i][k] = '0; m_p[i][k] = '0;
                end
            end else if (!m_br[i]) begin
                if (mode && m_cnt[i] > 0) begin
                    m_br[i] = 1; m_cur[i] = m_cnt[i] - 1;
                end else if (!mode && btn_select && m_cnt[i] < turns[i]) begin
                    m_g[i][m_cnt[i]] = guess_in & gmask[i];
                    m_e[i][m_cnt[i]] = fe;
                    m_p[i][m_cnt[i]] = fp;
                    m_cur[i] = m_cnt[i];
                    m_cnt[i]++;
                end
            end else begin
                if (!mode) begin
                    m_br[i] = 0; m_cur[i] = m_cnt[i] - 1;
                end else if (btn_up && !btn_down) begin
                    m_cur[i] = (m_cur[i] < m_cnt[i] - 1) ? m_cur[i] + 1 : m_cur[i];
                end else if (btn_down && !btn_up) begin
                    m_cur[i] = (m_cur[i] > 0) ? m_cur[i] - 1 : 0;
                end
            end
        end
    endtask

    function automatic logic [35:0] exp_vec(input int i);
        logic [17:0] g;
        logic [2:0]  e, p;
        logic [3:0]  st;
        logic [4:0]  tc;
        bit          v;
        v  = m_cnt[i] > 0;
        g  = v ? m_g[i][m_cur[i]] : '0;
        e  = v ? m_e[i][m_cur[i]] : '0;
        p  = v ? m_p[i][m_cur[i]] : '0;
        st = 4'(m_cur[i]);
        tc = 5'(m_cnt[i]);
        return {g, e, p, st, v, tc, m_cnt[i] == turns[i] - 1, m_cnt[i] == turns[i]};
    endfunction

    task automatic cycle();
        model_update();
        @(posedge clk);
        #1;
        reset = 0; btn_up = 0; btn_down = 0; btn_select = 0;
    endtask

    task automatic commit_random();
        mode = 0; btn_select = 1;
        guess_in = 18'($urandom);
        fe = 3'($urandom_range(0, 4));
        fp = 3'($urandom_range(0, 4));
        cycle();
    endtask

    task automatic test_reset();
        reset = 1; mode = 0;
        cycle();
        for (int i = 0; i < 2; i++) begin
            total++;
            if (obs[i] !== 36'd0) begin
                $display("FAIL reset inst%0d got=%h want=0", i, obs[i]); bad++;
            end
        end
    endtask

    task automatic test_first_commit();
        reset = 1; cycle();
        mode = 0; btn_select = 1; guess_in = 18'o1234; fe = 3'd2; fp = 3'd1;
        cycle();
        total++;
        if ({a_sg, a_se, a_sp, a_st, a_tc, a_sv} !== {12'o1234, 3'd2, 3'd1, 3'd0, 4'd1, 1'b1}) begin
            $display("FAIL first_commit got=%o/%0d/%0d/t%0d/c%0d/v%0d want=1234/2/1/t0/c1/v1",
                     a_sg, a_se, a_sp, a_st, a_tc, a_sv);
            bad++;
        end
        for (int i = 0; i < 2; i++) begin
            total++;
            if (obs[i] !== exp_vec(i)) begin
                $display("FAIL first_commit_model inst%0d got=%h want=%h", i, obs[i], exp_vec(i)); bad++;
            end
        end
    endtask

    task automatic test_fill();
        logic [11:0] g7;
        reset = 1; cycle();
        g7 = '0;
        for (int k = 1; k <= 11; k++) begin
            commit_random();
            if (k == 8) g7 = guess_in[11:0];
            for (int i = 0; i < 2; i++) begin
                total++;
                if (obs[i] !== exp_vec(i)) begin
                    $display("FAIL fill_model k=%0d inst%0d got=%h want=%h", k, i, obs[i], exp_vec(i)); bad++;
                end
            end
            total++;
            if ({a_lt, a_fu, b_lt, b_fu} !== {k == 7, k >= 8, k == 9, k >= 10}) begin
                $display("FAIL fill_flags k=%0d got=%b want=%b", k, {a_lt, a_fu, b_lt, b_fu},
                         {k == 7, k >= 8, k == 9, k >= 10});
                bad++;
            end
        end
        total++;
        if ({a_tc, b_tc, a_st, a_sg} !== {4'd8, 5'd10, 3'd7, g7}) begin
            $display("FAIL fill_saturate got=%0d/%0d/t%0d/%h want=8/10/t7/%h", a_tc, b_tc, a_st, a_sg, g7);
            bad++;
        end
        mode = 1; cycle();
        total++;
        if ({a_st, b_st} !== {3'd7, 4'd9}) begin
            $display("FAIL fill_browse_latest got=%0d/%0d want=7/9", a_st, b_st); bad++;
        end
        mode = 0; cycle();
    endtask

    task automatic test_browse();
        int want [6] = '{1, 0, 0, 1, 2, 2};
        reset = 1; cycle();
        for (int k = 0; k < 3; k++) commit_random();
        mode = 1; cycle();
        total++;
        if ({a_st, b_st} !== {3'd2, 4'd2}) begin
            $display("FAIL browse_enter got=%0d/%0d want=2/2", a_st, b_st); bad++;
        end
        for (int s = 0; s < 6; s++) begin
            if (s < 3) btn_down = 1; else btn_up = 1;
            cycle();
            total++;
            if (int'(a_st) != want[s] || int'(b_st) != want[s]) begin
                $display("FAIL browse_step s=%0d got=%0d/%0d want=%0d", s, a_st, b_st, want[s]); bad++;
            end
            for (int i = 0; i < 2; i++) begin
                total++;
                if (obs[i] !== exp_vec(i)) begin
                    $display("FAIL browse_model s=%0d inst%0d got=%h want=%h", s, i, obs[i], exp_vec(i)); bad++;
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        btn_down = 1; cycle();
        btn_up = 1; btn_down = 1; cycle();
        total++;
        if ({a_st, b_st} !== {3'd1, 4'd1}) begin
            $display("FAIL both_buttons got=%0d/%0d want=1/1", a_st, b_st); bad++;
        end
        btn_select = 1; guess_in = 18'($urandom); fe = 3'd4; fp = 3'd0; cycle();
        total++;
        if ({a_tc, b_tc} !== {4'd3, 5'd3}) begin
            $display("FAIL select_in_history got=%0d/%0d want=3/3", a_tc, b_tc); bad++;
        end
        mode = 0; cycle();
        for (int i = 0; i < 2; i++) begin
            total++;
            if (obs[i] !== exp_vec(i)) begin
                $display("FAIL return_live inst%0d got=%h want=%h", i, obs[i], exp_vec(i)); bad++;
            end
        end
    endtask

    task automatic test_reset_mid_browse();
        reset = 1; cycle();
        for (int k = 0; k < 5; k++) commit_random();
        mode = 1; cycle();
        for (int k = 0; k < 3; k++) begin btn_down = 1; cycle(); end
        total++;
        if ({a_st, a_tc} !== {3'd1, 4'd5}) begin
            $display("FAIL pre_reset got=t%0d/c%0d want=t1/c5", a_st, a_tc); bad++;
        end
        reset = 1; cycle();
        for (int i = 0; i < 2; i++) begin
            total++;
            if (obs[i] !== 36'd0) begin
                $display("FAIL mid_browse_reset inst%0d got=%h want=0", i, obs[i]); bad++;
            end
        end
        btn_up = 1; cycle();
        btn_select = 1; cycle();
        total++;
        if ({a_sv, b_sv, a_tc, b_tc} !== 11'd0) begin
            $display("FAIL empty_history got=%b want=0", {a_sv, b_sv, a_tc, b_tc}); bad++;
        end
        mode = 0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset      = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 9) == 0) mode = ~mode;
            btn_up     = $urandom_range(0, 2) == 0;
            btn_down   = $urandom_range(0, 2) == 0;
            btn_select = $urandom_range(0, 1) == 0;
            guess_in   = 18'($urandom);
            fe         = 3'($urandom_range(0, 4));
            fp         = 3'($urandom_range(0, 4));
            cycle();
            for (int i = 0; i < 2; i++) begin
                total++;
                if (obs[i] !== exp_vec(i)) begin
                    $display("FAIL random n=%0d inst%0d got=%h want=%h", n, i, obs[i], exp_vec(i)); bad++;
                end
            end
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_first_commit();
        test_fill();
        test_browse();
        test_back_to_back();
        test_reset_mid_browse();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
